// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_param
// Purpose  : Sequential shift-and-add multiplier with signed/unsigned mode,
//            start/busy/done handshake and early termination.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PW-1:0]    r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [c_PW-1:0]    r_acc;
    logic               r_neg;
    logic [c_PW-1:0]    r_product;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_mag_b_shr;
    logic               w_accept;

    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    assign w_neg_a     = signed_mode & op_a[WIDTH-1];
    assign w_neg_b     = signed_mode & op_b[WIDTH-1];
    assign w_abs_a     = w_neg_a ? (-op_a) : op_a;
    assign w_abs_b     = w_neg_b ? (-op_b) : op_b;
    assign w_mag_b_shr = r_mag_b >> 1;
    assign w_accept    = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_mag_b_shr == '0) w_state_nxt = S_SIGN;
            S_SIGN:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mag_a <= {{WIDTH{1'b0}}, w_abs_a};
                r_mag_b <= w_abs_b;
                r_acc   <= '0;
                r_neg   <= w_neg_a ^ w_neg_b;
            end else if (r_state == S_CALC) begin
                if (r_mag_b[0]) begin
                    r_acc <= r_acc + r_mag_a;
                end
                r_mag_a <= r_mag_a << 1;
                r_mag_b <= w_mag_b_shr;
            end
            // -0 is 0 in two's complement, so a zero product stays zero.
            if (r_state == S_SIGN) begin
                r_product <= r_neg ? (-r_acc) : r_acc;
            end
        end
    end

    assign busy    = (r_state == S_CALC) | (r_state == S_SIGN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_param
// Purpose  : Randomised self-checking bench for seq_mult_param (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int errors;
    logic [2*W-1:0] prev_product;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sm);
        longint pa;
        longint pb;
        longint p;
        pa = sm ? longint'($signed(a)) : longint'(a);
        pb = sm ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Iterations needed: bit length of |b|, at least one.
    function automatic int ref_k(input logic [W-1:0] b, input logic sm);
        longint m;
        int k;
        m = sm ? longint'($signed(b)) : longint'(b);
        if (m < 0) m = -m;
        k = 1;
        for (int i = 0; i < W + 1; i++) begin
            if (m[i]) k = i + 1;
        end
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start=1 and advances past the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        start       = 1'b1;
        op_a        = a;
        op_b        = b;
        signed_mode = sm;
        step();
        start = 1'b0;
    endtask

    // Follows one accepted operation up to its done cycle; optional input noise while busy.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, input bit noise);
        logic [2*W-1:0] exp_p;
        int k;
        int n;
        int busy_cnt;
        exp_p    = ref_prod(a, b, sm);
        k        = ref_k(b, sm);
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 4 * W) begin
            if (busy) busy_cnt++;
            if (n <= k) begin
                checks++;
                if (product !== prev_product) begin
                    errors++;
                    $display("FAIL %s hold n=%0d: product=%h required %h", name, n, product, prev_product);
                end
            end
            if (noise && busy) begin
                start       = 1'($urandom);
                op_a        = W'($urandom);
                op_b        = W'($urandom);
                signed_mode = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done=%b required 1", name, done);
        end
        checks++;
        if (n != k + 1) begin
            errors++;
            $display("FAIL %s latency: %0d edges required %0d", name, n, k + 1);
        end
        checks++;
        if (busy_cnt != k + 1) begin
            errors++;
            $display("FAIL %s busy cycles: %0d required %0d", name, busy_cnt, k + 1);
        end
        checks++;
        if (product !== exp_p) begin
            errors++;
            $display("FAIL %s product %h*%h sm=%b: got %h required %h", name, a, b, sm, product, exp_p);
        end
        prev_product = exp_p;
    endtask

    // One idle cycle after done: pulse must end and product must hold.
    task automatic check_idle_after(input string name);
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b required 0 0", name, done, busy);
        end
        checks++;
        if (product !== prev_product) begin
            errors++;
            $display("FAIL %s held product: %h required %h", name, product, prev_product);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        rst = 1'b0;
        prev_product = '0;
        step();
    endtask

    task automatic test_unsigned();
        start_op(8'd13, 8'd11, 1'b0);
        run_op("u13x11", 8'd13, 8'd11, 1'b0, 1'b0);
        check_idle_after("u13x11");
        start_op(8'd255, 8'd255, 1'b0);
        run_op("u255x255", 8'd255, 8'd255, 1'b0, 1'b0);
        check_idle_after("u255x255");
        start_op(8'd200, 8'd0, 1'b0);
        run_op("u200x0", 8'd200, 8'd0, 1'b0, 1'b0);
        check_idle_after("u200x0");
    endtask

    task automatic test_signed();
        logic [W-1:0] av[4];
        logic [W-1:0] bv[4];
        av = '{8'hFD, 8'h80, 8'h7F, 8'h00};
        bv = '{8'h05, 8'h80, 8'h80, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            start_op(av[i], bv[i], 1'b1);
            run_op("signed_corner", av[i], bv[i], 1'b1, 1'b0);
            check_idle_after("signed_corner");
        end
    endtask

    task automatic test_busy_noise();
        start_op(8'd100, 8'd77, 1'b0);
        run_op("noise", 8'd100, 8'd77, 1'b0, 1'b1);
        check_idle_after("noise");
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL noise extra op: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        start_op(8'd3, 8'd5, 1'b0);
        run_op("b2b_first", 8'd3, 8'd5, 1'b0, 1'b0);
        start_op(8'd6, 8'd7, 1'b0);
        run_op("b2b_second", 8'd6, 8'd7, 1'b0, 1'b0);
        check_idle_after("b2b_second");
    endtask

    task automatic test_reset_mid_op();
        start_op(8'h55, 8'hFF, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL mid reset: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        prev_product = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL mid reset stray done: done=%b required 0", done);
            end
        end
        start_op(8'd9, 8'd9, 1'b0);
        run_op("after_reset_9x9", 8'd9, 8'd9, 1'b0, 1'b0);
        check_idle_after("after_reset_9x9");
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic sm;
        for (int i = 0; i < 40; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            sm = 1'($urandom);
            if (i % 5 == 0) b = W'($urandom_range(0, 3));
            start_op(a, b, sm);
            run_op("random", a, b, sm, 1'($urandom));
            if ($urandom_range(0, 1) == 0) check_idle_after("random");
        end
        check_idle_after("random_end");
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        prev_product = '0;
        rst          = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        op_a         = '0;
        op_b         = '0;
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_busy_noise();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
